// File: rtl/out_mem_reader.sv
// out_mem_reader: drains the T x M result matrix from OUT_MEM onto a valid/ready stream, row-major, two words per row.
// Define OUT_MEM_PAD_CHECK_EN to add a sticky PAD_ERR flag for nonzero lanes in columns beyond the latched M.
// state | meaning
// IDLE  | waiting for START
// READ  | issuing reads 0..W-1 while FIFO credit allows
// DRAIN | last read issued; waiting for FIFO and read pipe to empty
module out_mem_reader #(
    parameter int DW         = 64,
    parameter int AW         = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [11:0]   MNT,
    output logic          EN_O,
    output logic          RW_O,
    output logic [AW-1:0] ADDR_O,
    input  logic [DW-1:0] RDATA_O,
    output logic [DW-1:0] DOUT,
    output logic          DVALID,
    input  logic          DREADY,
    output logic          DLAST,
    output logic          BUSY,
`ifdef OUT_MEM_PAD_CHECK_EN
    output logic          PAD_ERR,
`endif
    output logic          DONE
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              m_q, m_d;
    logic [4:0]              w_q, w_d;
    logic [4:0]              issue_q, issue_d;
    logic [4:0]              pend_addr_q, pend_addr_d;
    logic                    pend_q, pend_d;
    logic                    bad_q, bad_d;
    logic [DW-1:0]           mem_q [FIFO_DEPTH];
    logic [DW-1:0]           mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   last_q, last_d;
    logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    issue, push, pop, start_ok, start_acc, drain_done;
    logic                    unused_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        w_d         = w_q;
        issue_d     = issue_q;
        bad_d       = 1'b0;
        issue       = 1'b0;
        drain_done  = 1'b0;
        start_ok    = (MNT[3:0] != 4'd0) && (MNT[3:0] <= 4'd8);
        start_acc   = 1'b0;
        push        = pend_q;
        pop         = (cnt_q != '0) && DREADY;

        case (state_q)
            IDLE: begin
                if (START) begin
                    if (start_ok) begin
                        start_acc = 1'b1;
                        m_d       = MNT[11:8];
                        w_d       = {MNT[3:0], 1'b0};
                        issue_d   = '0;
                        state_d   = READ;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            READ: begin
                // Credit counts the word still on its way back from the SRAM.
                if ((int'(cnt_q) + int'(pend_q)) < FIFO_DEPTH) begin
                    issue   = 1'b1;
                    issue_d = issue_q + 5'd1;
                    if (issue_q == w_q - 5'd1) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((cnt_q == '0) && !pend_q) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pend_d      = issue;
        pend_addr_d = issue ? issue_q : pend_addr_q;

        mem_d  = mem_q;
        last_d = last_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        if (push) begin
            mem_d[wr_q]  = RDATA_O;
            last_d[wr_q] = (pend_addr_q == w_q - 5'd1);
            wr_d         = ptr_inc(wr_q);
        end
        if (pop) rd_d = ptr_inc(rd_q);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            m_q         <= '0;
            w_q         <= '0;
            issue_q     <= '0;
            pend_addr_q <= '0;
            pend_q      <= 1'b0;
            bad_q       <= 1'b0;
            mem_q       <= '{default: '0};
            last_q      <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            w_q         <= w_d;
            issue_q     <= issue_d;
            pend_addr_q <= pend_addr_d;
            pend_q      <= pend_d;
            bad_q       <= bad_d;
            mem_q       <= mem_d;
            last_q      <= last_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
        end
    end

    assign EN_O      = issue;
    assign RW_O      = 1'b0;
    assign ADDR_O    = issue ? AW'(issue_q) : '0;
    assign DVALID    = (cnt_q != '0);
    assign DOUT      = DVALID ? mem_q[rd_q] : '0;
    assign DLAST     = DVALID && last_q[rd_q];
    assign BUSY      = (state_q != IDLE);
    assign DONE      = drain_done || bad_q;
    assign unused_ok = ^{MNT[7:4], m_q};

`ifdef OUT_MEM_PAD_CHECK_EN
    logic pad_q, pad_d;

    // Column of lane k is 4*(addr%2)+k+1; any nonzero lane past M is padding that should have been zero.
    always_comb begin
        pad_d = pad_q;
        if (start_acc) pad_d = 1'b0;
        if (push) begin
            for (int k = 0; k < 4; k++) begin
                if ((RDATA_O[DW-1-16*k -: 16] != 16'd0) &&
                    ((4 * int'(pend_addr_q[0]) + k + 1) > int'(m_q)))
                    pad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) pad_q <= 1'b0;
        else     pad_q <= pad_d;
    end

    assign PAD_ERR = pad_q;
`endif

endmodule

// File: tb/tb_out_mem_reader.sv
// Bench for out_mem_reader: SRAM model, reference stream queue, randomized descriptors and ready patterns.
`timescale 1ns/1ps
module tb_out_mem_reader;

    logic        CLK = 1'b0;
    logic        RST, START, DREADY;
    logic [11:0] MNT;
    logic        EN_O, RW_O;
    logic [3:0]  ADDR_O;
    logic [63:0] RDATA_O, DOUT;
    logic        DVALID, DLAST, BUSY, DONE;
`ifdef OUT_MEM_PAD_CHECK_EN
    logic        PAD_ERR;
`endif

    out_mem_reader dut (
        .CLK(CLK), .RST(RST), .START(START), .MNT(MNT),
        .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O), .RDATA_O(RDATA_O),
        .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY), .DLAST(DLAST),
        .BUSY(BUSY),
`ifdef OUT_MEM_PAD_CHECK_EN
        .PAD_ERR(PAD_ERR),
`endif
        .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0, n_err = 0, cyc = 0;
    logic [63:0] sram [16];
    logic [63:0] exp_d [$];
    logic        exp_l [$];
    int          exp_addr = 0, n_issue = 0, beats = 0, done_cnt = 0;
    int          done_cyc = 0, last_beat_cyc = 0, buffered = 0;
    logic        en_prev = 1'b0, hold_prev = 1'b0;
    logic [63:0] hold_data = '0;
    int          rdy_mode = 0, ph = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // OUT_MEM model: data one cycle after enable, junk otherwise.
    always @(posedge CLK) begin
        if (EN_O) RDATA_O <= sram[ADDR_O];
        else      RDATA_O <= {$urandom(), $urandom()};
    end

    initial begin
        DREADY = 1'b1;
        forever begin
            @(posedge CLK); #1;
            ph++;
            case (rdy_mode)
                0:       DREADY = 1'b1;
                1:       DREADY = ((ph % 4) == 0) || ((ph % 4) == 3);
                default: DREADY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Stream / address monitor against the reference queue.
    always @(negedge CLK) begin
        if (RST) begin
            buffered  = 0;
            en_prev   = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (EN_O) begin
                chk("addr_order", ADDR_O, exp_addr);
                chk("credit", (buffered + int'(en_prev)) < 2, 1);
                exp_addr++;
                n_issue++;
            end
            chk("dvalid_vs_buffer", DVALID, buffered > 0);
            if (hold_prev) begin
                chk("hold_valid", DVALID, 1);
                chk("hold_data", DOUT, hold_data);
            end
            if (DVALID && DREADY) begin
                chk("beat_expected", exp_d.size() != 0, 1);
                if (exp_d.size() != 0) begin
                    chk("dout", DOUT, exp_d.pop_front());
                    chk("dlast", DLAST, exp_l.pop_front());
                end
                beats++;
                last_beat_cyc = cyc;
            end
            if (DONE) begin
                done_cnt++;
                done_cyc = cyc;
            end
            hold_prev = DVALID && !DREADY;
            hold_data = DOUT;
            buffered  = buffered + int'(en_prev) - int'(DVALID && DREADY);
            en_prev   = EN_O;
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_en"}, EN_O, 0);
        chk({tag, "_rw"}, RW_O, 0);
        chk({tag, "_addr"}, ADDR_O, 0);
        chk({tag, "_dvalid"}, DVALID, 0);
        chk({tag, "_dlast"}, DLAST, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_dout"}, DOUT, 0);
`ifdef OUT_MEM_PAD_CHECK_EN
        chk({tag, "_pad"}, PAD_ERR, 0);
`endif
    endtask

    task automatic load_expected(input int w);
        exp_addr = 0;
        for (int i = 0; i < w; i++) begin
            exp_d.push_back(sram[i]);
            exp_l.push_back(i == w - 1);
        end
    endtask

    task automatic run(input logic [11:0] mnt, input bit inject);
        int t, w, s, b0, i0, d0;
        bit valid, seen;
        t     = int'(mnt[3:0]);
        valid = (t >= 1) && (t <= 8);
        w     = valid ? 2 * t : 0;
        load_expected(w);
        b0 = beats; i0 = n_issue; d0 = done_cnt;
        @(posedge CLK); #1;
        START = 1'b1; MNT = mnt; s = cyc;
        @(posedge CLK); #1;
        START = 1'b0; MNT = 12'($urandom());
        @(negedge CLK); #1;
        chk("busy_start", BUSY, valid);
        seen = 1'b0;
        for (int it = 0; it < 400 && !seen; it++) begin
            if (done_cnt != d0) seen = 1'b1;
            else begin
                if (inject && it == 2) begin START = 1'b1; MNT = 12'h111; end
                if (inject && it == 3) START = 1'b0;
                @(negedge CLK); #1;
            end
        end
        START = 1'b0;
        chk("done_seen", seen, 1);
        chk("beats", beats - b0, w);
        chk("issues", n_issue - i0, w);
        chk("exp_left", exp_d.size(), 0);
        if (valid) chk("done_lat", done_cyc, last_beat_cyc + 1);
        else       chk("done_lat", done_cyc, s + 1);
        exp_d.delete(); exp_l.delete();
        @(negedge CLK); #1;
        chk("busy_end", BUSY, 0);
        chk("done_pulse", DONE, 0);
    endtask

    initial begin
        int b0, t, m, n;
        RST = 1'b1; START = 1'b0; MNT = '0;
        for (int i = 0; i < 16; i++) sram[i] = {$urandom(), $urandom()};
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset("rst");
        @(posedge CLK); #1;
        RST = 1'b0;

        rdy_mode = 0; run(12'h333, 1'b0);
        rdy_mode = 1; run(12'h888, 1'b0);
        rdy_mode = 0; run(12'h330, 1'b0);
        run(12'h339, 1'b0);
        run(12'h333, 1'b1);

        // Abort mid-run, then restart cleanly.
        load_expected(6);
        b0 = beats;
        @(posedge CLK); #1; START = 1'b1; MNT = 12'h333;
        @(posedge CLK); #1; START = 1'b0;
        for (int it = 0; it < 100 && (beats - b0) < 3; it++) begin
            @(negedge CLK); #1;
        end
        chk("rst_wait", (beats - b0) >= 3, 1);
        @(posedge CLK); #1; RST = 1'b1;
        @(posedge CLK); #1; RST = 1'b0;
        exp_d.delete(); exp_l.delete();
        @(negedge CLK);
        check_reset("abort");
        run(12'h111, 1'b0);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 16; i++) sram[i] = {$urandom(), $urandom()};
            rdy_mode = $urandom_range(0, 2);
            t = $urandom_range(0, 9);
            m = $urandom_range(1, 8);
            n = $urandom_range(1, 8);
            run({4'(m), 4'(n), 4'(t)}, 1'($urandom_range(0, 1)));
        end

`ifdef OUT_MEM_PAD_CHECK_EN
        rdy_mode = 0;
        sram[0] = 64'h0001_0002_0003_0004;
        sram[1] = 64'h0;
        run(12'h311, 1'b0);
        chk("pad_set", PAD_ERR, 1);
        repeat (3) @(negedge CLK);
        chk("pad_sticky", PAD_ERR, 1);
        sram[0] = 64'h0001_0002_0003_0000;
        run(12'h311, 1'b0);
        chk("pad_clear", PAD_ERR, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
